// File: rtl/arith_seg_pkg.sv
// ----------------------------------------------------------------------------
// arith_seg_pkg
//   Shared definitions for the arith_seg_scan display slice.
//   - SEL_* : result-select codes for the 'sel' input of arith_seg_scan
//   - seg_t : seven-segment pattern {g,f,e,d,c,b,a}, active-low (0 = lit)
//   - SEG_BLANK : all segments dark
//   - hex_to_seg() : nibble -> active-low hex glyph (0-9, A, b, C, d, E, F)
// ----------------------------------------------------------------------------
package arith_seg_pkg;

    localparam logic [1:0] SEL_SUM  = 2'b00;
    localparam logic [1:0] SEL_COUT = 2'b01;
    localparam logic [1:0] SEL_DIFF = 2'b10;
    localparam logic [1:0] SEL_BOUT = 2'b11;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t s;
        case (nibble)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// ----------------------------------------------------------------------------
// seg_hex_decode
//   Combinational nibble to seven-segment decoder (wraps hex_to_seg).
//   Ports:
//     nibble  in  4  hex digit value
//     seg     out 7  {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module seg_hex_decode
    import arith_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/arith_seg_scan.sv
// ----------------------------------------------------------------------------
// arith_seg_scan
//   Add/subtract result selector with a capture register and a multiplexed
//   hex seven-segment driver for DIGITS common-anode digits.
//   Parameters: WIDTH (operand bits), DIGITS (hex digits shown),
//               SCAN_DIV (clk cycles each digit is held, >= 2).
//   Ports:
//     clk          in   1       rising-edge clock
//     rst_n        in   1       asynchronous reset, active-low
//     a_in, b_in   in   WIDTH   operands
//     c_in         in   1       carry-in (add) / borrow-in (subtract)
//     sel          in   2       00 sum, 01 carry-out, 10 difference, 11 borrow-out
//     load         in   1       capture selected result on this edge
//     shown_valid  out  1       a load has been captured since reset
//     seg          out  7       {g,f,e,d,c,b,a}, active-low
//     an           out  DIGITS  digit enables, one-hot active-low
//   Build option: define ARITH_SEG_LZ_BLANK_EN to blank leading-zero digits
//   (digit 0 always shows). Without it every digit shows its nibble.
// ----------------------------------------------------------------------------
module arith_seg_scan
    import arith_seg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic              c_in,
    input  logic [1:0]        sel,
    input  logic              load,
    output logic              shown_valid,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int DIDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PAD_W  = DIGITS * 4;

    generate
        if (PAD_W < WIDTH) begin : g_width_chk
            $error("arith_seg_scan: DIGITS*4 must be >= WIDTH");
        end
    endgenerate

    // One extra bit catches carry-out / borrow-out. For subtraction the top
    // bit is set exactly when a_in < b_in + c_in (result went negative).
    logic [WIDTH:0]   sum_full;
    logic [WIDTH:0]   diff_full;
    logic [WIDTH-1:0] sel_val;

    assign sum_full  = {1'b0, a_in} + {1'b0, b_in} + (WIDTH+1)'(c_in);
    assign diff_full = {1'b0, a_in} - {1'b0, b_in} - (WIDTH+1)'(c_in);

    always_comb begin
        sel_val = '0;
        case (sel)
            SEL_SUM:  sel_val = sum_full[WIDTH-1:0];
            SEL_COUT: sel_val = WIDTH'(sum_full[WIDTH]);
            SEL_DIFF: sel_val = diff_full[WIDTH-1:0];
            default:  sel_val = WIDTH'(diff_full[WIDTH]);
        endcase
    end

    logic [WIDTH-1:0]  disp_q;
    logic [CNT_W-1:0]  pres_cnt;
    logic [DIDX_W-1:0] digit_idx;
    logic              tick;

    assign tick = (pres_cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q      <= '0;
            shown_valid <= 1'b0;
            pres_cnt    <= '0;
            digit_idx   <= '0;
        end else begin
            if (load) begin
                disp_q      <= sel_val;
                shown_valid <= 1'b1;
            end
            pres_cnt <= tick ? '0 : pres_cnt + 1'b1;
            if (tick) begin
                digit_idx <= (digit_idx == DIDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Zero-pad the held value to whole nibbles so upper digits read as 0.
    logic [PAD_W-1:0] disp_pad;
    logic [3:0]       cur_nib;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_d;

    always_comb begin
        disp_pad = '0;
        disp_pad[WIDTH-1:0] = disp_q;
    end

    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == DIDX_W'(i)) cur_nib = disp_pad[i*4 +: 4];
        end
    end

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

`ifdef ARITH_SEG_LZ_BLANK_EN
    // Scan from the most significant nibble down; a digit is blank while
    // nothing at or above it is non-zero. Digit 0 always shows.
    logic [DIGITS-1:0] blank;
    logic              upper_nz;

    always_comb begin
        blank    = '0;
        upper_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (|disp_pad[i*4 +: 4]);
            if (i != 0) blank[i] = ~upper_nz;
        end
    end

    assign seg_d = blank[digit_idx] ? SEG_BLANK : dec_seg;
`else
    assign seg_d = dec_seg;
`endif

    // Output registers sample the pre-edge value and digit, so a load shows
    // up on the display one edge after it is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_d;
            an  <= ~(DIGITS'(1) << digit_idx);
        end
    end

endmodule
